// File: rtl/rx_ethertype_router.sv
// RX ethertype router: filters parsed frames by destination MAC and steers the payload
// to one of two AXI-Stream ports by ethertype, with overrun truncation and statistics.
module rx_ethertype_router #(
    parameter logic [15:0] ETYPE0 = 16'h0800,
    parameter logic [15:0] ETYPE1 = 16'h0806,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk125,
    input  logic             rst,
    input  logic [47:0]      cfg_mac,
    input  logic             cfg_promisc,
    input  logic             cfg_mcast_en,
    input  logic             frame_start,
    input  logic [47:0]      dest_mac,
    input  logic [15:0]      ethertype,
    input  logic             s_tvalid,
    input  logic [7:0]       s_tdata,
    input  logic             s_tlast,
    output logic             m0_tvalid,
    output logic [7:0]       m0_tdata,
    output logic             m0_tlast,
    output logic             m0_tuser,
    input  logic             m0_tready,
    output logic             m1_tvalid,
    output logic [7:0]       m1_tdata,
    output logic             m1_tlast,
    output logic             m1_tuser,
    input  logic             m1_tready,
    output logic [CNT_W-1:0] cnt_fwd0,
    output logic [CNT_W-1:0] cnt_fwd1,
    output logic [CNT_W-1:0] cnt_drop,
    output logic [CNT_W-1:0] cnt_ovr
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HDR     = 3'd1;
    localparam logic [2:0] FWD     = 3'd2;
    localparam logic [2:0] DISCARD = 3'd3;
    localparam logic [2:0] ABORT   = 3'd4;

    logic [2:0] state_q, state_d;
    logic       sel_q, sel_d;
    logic       term_q, term_d;   // terminator already loaded in ABORT
    logic       pend_q, pend_d;   // frame_start seen while aborting
    logic       dmg_q, dmg_d;     // pending frame lost beats during ABORT
    logic       done_q, done_d;   // pending frame already saw its tlast

    logic       accept, routed, new_sel;
    logic       xfer0, xfer1, free0, free1;
    logic       free_sel, xfer_sel, free_new;
    logic       ld_en, ld_port, ld_last, ld_user;
    logic [7:0] ld_data;
    logic       ld0, ld1;
    logic       inc_drop, inc_ovr, inc_fwd0, inc_fwd1;

    assign accept  = cfg_promisc || (dest_mac == cfg_mac) || (dest_mac == 48'hFFFF_FFFF_FFFF)
                     || (cfg_mcast_en && dest_mac[40]);
    assign routed  = (ethertype == ETYPE0) || (ethertype == ETYPE1);
    assign new_sel = (ethertype != ETYPE0);

    assign xfer0    = m0_tvalid & m0_tready;
    assign xfer1    = m1_tvalid & m1_tready;
    assign free0    = ~m0_tvalid | m0_tready;
    assign free1    = ~m1_tvalid | m1_tready;
    assign free_sel = sel_q ? free1 : free0;
    assign xfer_sel = sel_q ? xfer1 : xfer0;
    assign free_new = new_sel ? free1 : free0;

    assign ld0 = ld_en & ~ld_port;
    assign ld1 = ld_en & ld_port;

    assign inc_fwd0 = xfer0 & m0_tlast & ~m0_tuser;
    assign inc_fwd1 = xfer1 & m1_tlast & ~m1_tuser;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        term_d   = term_q;
        pend_d   = pend_q;
        dmg_d    = dmg_q;
        done_d   = done_q;
        ld_en    = 1'b0;
        ld_port  = sel_q;
        ld_data  = s_tdata;
        ld_last  = s_tlast;
        ld_user  = 1'b0;
        inc_drop = 1'b0;
        inc_ovr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) state_d = HDR;
            end
            HDR: begin
                if (frame_start) begin
                    state_d = HDR;
                end else if (s_tvalid) begin
                    if (accept && routed) begin
                        sel_d = new_sel;
                        if (free_new) begin
                            ld_en   = 1'b1;
                            ld_port = new_sel;
                            state_d = s_tlast ? IDLE : FWD;
                        end else begin
                            // Previous frame's tail still stalled on this port.
                            inc_ovr = 1'b1;
                            term_d  = 1'b0;
                            pend_d  = 1'b0;
                            dmg_d   = 1'b0;
                            done_d  = 1'b0;
                            state_d = ABORT;
                        end
                    end else begin
                        inc_drop = 1'b1;
                        state_d  = s_tlast ? IDLE : DISCARD;
                    end
                end
            end
            FWD: begin
                if (frame_start) begin
                    inc_ovr = 1'b1;
                    term_d  = 1'b0;
                    pend_d  = 1'b1;
                    dmg_d   = 1'b0;
                    done_d  = 1'b0;
                    state_d = ABORT;
                end else if (s_tvalid) begin
                    if (free_sel) begin
                        ld_en = 1'b1;
                        if (s_tlast) state_d = IDLE;
                    end else begin
                        inc_ovr = 1'b1;
                        term_d  = 1'b0;
                        pend_d  = 1'b0;
                        dmg_d   = 1'b0;
                        done_d  = 1'b0;
                        state_d = ABORT;
                    end
                end
            end
            DISCARD: begin
                if (frame_start) begin
                    state_d = HDR;
                end else if (s_tvalid && s_tlast) begin
                    state_d = IDLE;
                end
            end
            ABORT: begin
                if (frame_start) begin
                    pend_d = 1'b1;
                    dmg_d  = 1'b0;
                    done_d = 1'b0;
                end else if (pend_q && s_tvalid) begin
                    // The pending frame is counted dropped once, on its first lost beat.
                    if (!dmg_q) inc_drop = 1'b1;
                    dmg_d = 1'b1;
                    if (s_tlast) done_d = 1'b1;
                end
                if (!term_q) begin
                    if (free_sel) begin
                        ld_en   = 1'b1;
                        ld_data = 8'h00;
                        ld_last = 1'b1;
                        ld_user = 1'b1;
                        term_d  = 1'b1;
                    end
                end else if (xfer_sel) begin
                    if (!pend_d)     state_d = IDLE;
                    else if (!dmg_d) state_d = HDR;
                    else if (done_d) state_d = IDLE;
                    else             state_d = DISCARD;
                    term_d = 1'b0;
                    pend_d = 1'b0;
                    dmg_d  = 1'b0;
                    done_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            term_q  <= 1'b0;
            pend_q  <= 1'b0;
            dmg_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            term_q  <= term_d;
            pend_q  <= pend_d;
            dmg_q   <= dmg_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            m0_tvalid <= 1'b0;
            m0_tdata  <= 8'h00;
            m0_tlast  <= 1'b0;
            m0_tuser  <= 1'b0;
        end else if (ld0) begin
            m0_tvalid <= 1'b1;
            m0_tdata  <= ld_data;
            m0_tlast  <= ld_last;
            m0_tuser  <= ld_user;
        end else if (xfer0) begin
            m0_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            m1_tvalid <= 1'b0;
            m1_tdata  <= 8'h00;
            m1_tlast  <= 1'b0;
            m1_tuser  <= 1'b0;
        end else if (ld1) begin
            m1_tvalid <= 1'b1;
            m1_tdata  <= ld_data;
            m1_tlast  <= ld_last;
            m1_tuser  <= ld_user;
        end else if (xfer1) begin
            m1_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            cnt_fwd0 <= '0;
            cnt_fwd1 <= '0;
            cnt_drop <= '0;
            cnt_ovr  <= '0;
        end else begin
            if (inc_fwd0 && (cnt_fwd0 != '1)) cnt_fwd0 <= cnt_fwd0 + CNT_W'(1);
            if (inc_fwd1 && (cnt_fwd1 != '1)) cnt_fwd1 <= cnt_fwd1 + CNT_W'(1);
            if (inc_drop && (cnt_drop != '1)) cnt_drop <= cnt_drop + CNT_W'(1);
            if (inc_ovr  && (cnt_ovr  != '1)) cnt_ovr  <= cnt_ovr  + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rx_ethertype_router.sv
// Self-checking bench for rx_ethertype_router: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_rx_ethertype_router;

    localparam int          CW     = 8;
    localparam logic [47:0] MAC_ME = 48'h02_00_00_00_00_01;
    localparam logic [47:0] MAC_NO = 48'h02_00_00_00_00_99;
    localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MCAST  = 48'h01_00_5E_00_00_01;
    localparam logic [CW-1:0] SAT  = '1;

    logic          clk125 = 1'b0;
    logic          rst;
    logic [47:0]   cfg_mac;
    logic          cfg_promisc, cfg_mcast_en;
    logic          frame_start;
    logic [47:0]   dest_mac;
    logic [15:0]   ethertype;
    logic          s_tvalid, s_tlast;
    logic [7:0]    s_tdata;
    logic          m0_tvalid, m0_tlast, m0_tuser, m0_tready;
    logic          m1_tvalid, m1_tlast, m1_tuser, m1_tready;
    logic [7:0]    m0_tdata, m1_tdata;
    logic [CW-1:0] cnt_fwd0, cnt_fwd1, cnt_drop, cnt_ovr;

    logic [9:0] q0[$], q1[$], eq0[$], eq1[$];
    logic [7:0] sent[$];
    int pass_cnt = 0;
    int total_cnt = 0;

    rx_ethertype_router #(.CNT_W(CW)) dut (
        .clk125(clk125), .rst(rst), .cfg_mac(cfg_mac), .cfg_promisc(cfg_promisc),
        .cfg_mcast_en(cfg_mcast_en), .frame_start(frame_start), .dest_mac(dest_mac),
        .ethertype(ethertype), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m0_tvalid(m0_tvalid), .m0_tdata(m0_tdata), .m0_tlast(m0_tlast), .m0_tuser(m0_tuser),
        .m0_tready(m0_tready), .m1_tvalid(m1_tvalid), .m1_tdata(m1_tdata),
        .m1_tlast(m1_tlast), .m1_tuser(m1_tuser), .m1_tready(m1_tready),
        .cnt_fwd0(cnt_fwd0), .cnt_fwd1(cnt_fwd1), .cnt_drop(cnt_drop), .cnt_ovr(cnt_ovr)
    );

    always #4 clk125 = ~clk125;

    // Transfers are captured on the falling edge, half a cycle from the active edge.
    always @(negedge clk125) begin
        if (!rst) begin
            if (m0_tvalid && m0_tready) q0.push_back({m0_tuser, m0_tlast, m0_tdata});
            if (m1_tvalid && m1_tready) q1.push_back({m1_tuser, m1_tlast, m1_tdata});
        end
    end

    initial begin
        #800us;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk125);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame_start = 1'b0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tdata = 8'h00;
        m0_tready = 1'b1;
        m1_tready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        q0.delete();
        q1.delete();
        eq0.delete();
        eq1.delete();
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input int len,
                              input int gap_max, input bit with_start, input bit scramble);
        logic [7:0] b;
        sent.delete();
        if (with_start) begin
            frame_start = 1'b1;
            cyc();
            frame_start = 1'b0;
        end
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(gap_max, 0)) cyc();
            b = 8'($urandom);
            sent.push_back(b);
            s_tvalid = 1'b1;
            s_tdata = b;
            s_tlast = (i == len - 1);
            dest_mac = dst;
            ethertype = et;
            cyc();
            s_tvalid = 1'b0;
            s_tlast = 1'b0;
            if (scramble && i == 0) begin
                cfg_promisc = 1'($urandom);
                cfg_mcast_en = 1'($urandom);
                cfg_mac = {16'($urandom), $urandom};
            end
        end
        dest_mac = {16'($urandom), $urandom};
        ethertype = 16'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_mac = MAC_ME;
        cfg_promisc = 1'b0;
        cfg_mcast_en = 1'b0;
        frame_start = 1'b0;
        dest_mac = '0;
        ethertype = '0;
        s_tvalid = 1'b0;
        s_tdata = 8'h00;
        s_tlast = 1'b0;
        m0_tready = 1'b1;
        m1_tready = 1'b1;
        cyc();
        total_cnt++;
        if ({m0_tvalid, m0_tdata, m0_tlast, m0_tuser, m1_tvalid, m1_tdata, m1_tlast, m1_tuser}
            !== 20'h0)
            $display("FAIL reset_outputs: got m0 %b/%h m1 %b/%h, want all 0",
                     m0_tvalid, m0_tdata, m1_tvalid, m1_tdata);
        else pass_cnt++;
        total_cnt++;
        if ({cnt_fwd0, cnt_fwd1, cnt_drop, cnt_ovr} !== '0)
            $display("FAIL reset_counters: got %h %h %h %h, want 0",
                     cnt_fwd0, cnt_fwd1, cnt_drop, cnt_ovr);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_ipv4_basic();
        logic [7:0] b;
        do_reset();
        cfg_mac = MAC_ME;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        for (int i = 0; i < 46; i++) begin
            b = 8'($urandom);
            s_tvalid = 1'b1;
            s_tdata = b;
            s_tlast = (i == 45);
            dest_mac = MAC_ME;
            ethertype = 16'h0800;
            cyc();
            total_cnt++;
            if (m0_tvalid !== 1'b1 || m0_tdata !== b || m0_tlast !== (i == 45) ||
                m0_tuser !== 1'b0 || m1_tvalid !== 1'b0)
                $display("FAIL ipv4_beat%0d: got v%b d%h l%b u%b m1v%b, want v1 d%h l%b u0 m1v0",
                         i, m0_tvalid, m0_tdata, m0_tlast, m0_tuser, m1_tvalid, b, (i == 45));
            else pass_cnt++;
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        cyc();
        cyc();
        total_cnt++;
        if (cnt_fwd0 !== CW'(1) || cnt_fwd1 !== '0 || cnt_drop !== '0 || cnt_ovr !== '0)
            $display("FAIL ipv4_counters: got %0d %0d %0d %0d, want 1 0 0 0",
                     cnt_fwd0, cnt_fwd1, cnt_drop, cnt_ovr);
        else pass_cnt++;
        total_cnt++;
        if (q0.size() != 46 || q1.size() != 0)
            $display("FAIL ipv4_beats: got %0d/%0d, want 46/0", q0.size(), q1.size());
        else pass_cnt++;
    endtask

    task automatic test_arp_bcast_mcast();
        int errs;
        do_reset();
        cfg_mcast_en = 1'b0;
        send_frame(BCAST, 16'h0806, 28, 0, 1'b1, 1'b0);
        repeat (3) cyc();
        errs = 0;
        for (int i = 0; i < 28; i++)
            if (i >= q1.size() || q1[i] !== {1'b0, (i == 27), sent[i]}) errs++;
        total_cnt++;
        if (q1.size() != 28 || errs != 0 || q0.size() != 0)
            $display("FAIL arp_bcast: got %0d beats %0d bad, want 28 beats 0 bad",
                     q1.size(), errs);
        else pass_cnt++;
        total_cnt++;
        if (cnt_fwd1 !== CW'(1))
            $display("FAIL arp_cnt_fwd1: got %0d, want 1", cnt_fwd1);
        else pass_cnt++;
        send_frame(MCAST, 16'h0806, 12, 1, 1'b1, 1'b0);
        repeat (3) cyc();
        total_cnt++;
        if (cnt_drop !== CW'(1) || q1.size() != 28)
            $display("FAIL mcast_off: got drop %0d beats %0d, want 1 28", cnt_drop, q1.size());
        else pass_cnt++;
        cfg_mcast_en = 1'b1;
        send_frame(MCAST, 16'h0806, 12, 1, 1'b1, 1'b0);
        repeat (3) cyc();
        total_cnt++;
        if (cnt_fwd1 !== CW'(2) || q1.size() != 40 || q1[39] !== {2'b01, sent[11]})
            $display("FAIL mcast_on: got fwd1 %0d beats %0d, want 2 40", cnt_fwd1, q1.size());
        else pass_cnt++;
        cfg_mcast_en = 1'b0;
    endtask

    task automatic test_drop();
        do_reset();
        cfg_promisc = 1'b0;
        send_frame(MAC_NO, 16'h0800, 20, 0, 1'b1, 1'b0);
        repeat (3) cyc();
        total_cnt++;
        if (cnt_drop !== CW'(1) || q0.size() != 0 || q1.size() != 0)
            $display("FAIL drop_mac: got drop %0d beats %0d/%0d, want 1 0/0",
                     cnt_drop, q0.size(), q1.size());
        else pass_cnt++;
        cfg_promisc = 1'b1;
        send_frame(MAC_NO, 16'h86DD, 20, 0, 1'b1, 1'b0);
        repeat (3) cyc();
        total_cnt++;
        if (cnt_drop !== CW'(2) || q0.size() != 0 || q1.size() != 0 || cnt_fwd0 !== '0)
            $display("FAIL drop_etype: got drop %0d beats %0d/%0d fwd0 %0d, want 2 0/0 0",
                     cnt_drop, q0.size(), q1.size(), cnt_fwd0);
        else pass_cnt++;
        cfg_promisc = 1'b0;
    endtask

    task automatic test_overrun();
        int errs;
        logic [7:0] b;
        logic [7:0] kept[$];
        do_reset();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            m0_tready = !(k >= 11 && k <= 13);
            b = 8'($urandom);
            kept.push_back(b);
            s_tvalid = 1'b1;
            s_tdata = b;
            s_tlast = (k == 20);
            dest_mac = MAC_ME;
            ethertype = 16'h0800;
            cyc();
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        m0_tready = 1'b1;
        repeat (3) cyc();
        errs = 0;
        for (int i = 0; i < 10; i++)
            if (i >= q0.size() || q0[i] !== {2'b00, kept[i]}) errs++;
        total_cnt++;
        if (q0.size() != 11 || errs != 0)
            $display("FAIL ovr_beats: got %0d beats %0d bad, want 11 beats 0 bad",
                     q0.size(), errs);
        else pass_cnt++;
        total_cnt++;
        if (q0.size() < 11 || q0[10] !== 10'h300)
            $display("FAIL ovr_terminator: got %h, want 300", (q0.size() > 10) ? q0[10] : 10'h0);
        else pass_cnt++;
        total_cnt++;
        if (cnt_ovr !== CW'(1) || cnt_fwd0 !== '0)
            $display("FAIL ovr_counters: got ovr %0d fwd0 %0d, want 1 0", cnt_ovr, cnt_fwd0);
        else pass_cnt++;
        send_frame(MAC_ME, 16'h0800, 10, 0, 1'b1, 1'b0);
        repeat (3) cyc();
        total_cnt++;
        if (cnt_fwd0 !== CW'(1) || q0.size() != 21 || q0[20] !== {2'b01, sent[9]})
            $display("FAIL ovr_recover: got fwd0 %0d beats %0d, want 1 21", cnt_fwd0, q0.size());
        else pass_cnt++;
    endtask

    task automatic test_midframe_start();
        logic [7:0] first[$];
        do_reset();
        send_frame(MAC_ME, 16'h0800, 5, 0, 1'b1, 1'b0);
        first = sent;
        // The 5-beat send above ends with tlast; replace with a truncated frame instead.
        do_reset();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 1'b1;
            s_tdata = first[i];
            dest_mac = MAC_ME;
            ethertype = 16'h0800;
            cyc();
        end
        s_tvalid = 1'b0;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        repeat (3) cyc();
        send_frame(BCAST, 16'h0806, 8, 0, 1'b0, 1'b0);
        repeat (3) cyc();
        total_cnt++;
        if (q0.size() != 6 || q0[0] !== {2'b00, first[0]} || q0[5] !== 10'h300)
            $display("FAIL fs_m0: got %0d beats last %h, want 6 beats last 300",
                     q0.size(), (q0.size() > 0) ? q0[q0.size() - 1] : 10'h0);
        else pass_cnt++;
        total_cnt++;
        if (q1.size() != 8 || q1[7] !== {2'b01, sent[7]})
            $display("FAIL fs_pending_fwd: got %0d beats, want 8", q1.size());
        else pass_cnt++;
        total_cnt++;
        if (cnt_ovr !== CW'(1) || cnt_fwd1 !== CW'(1) || cnt_drop !== '0 || cnt_fwd0 !== '0)
            $display("FAIL fs_counters: got ovr %0d fwd1 %0d drop %0d fwd0 %0d, want 1 1 0 0",
                     cnt_ovr, cnt_fwd1, cnt_drop, cnt_fwd0);
        else pass_cnt++;

        // New frame's beats arrive while the old one is still being terminated.
        do_reset();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 1'b1;
            s_tdata = first[i];
            dest_mac = MAC_ME;
            ethertype = 16'h0800;
            cyc();
        end
        s_tvalid = 1'b0;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        send_frame(BCAST, 16'h0806, 8, 0, 1'b0, 1'b0);
        repeat (3) cyc();
        total_cnt++;
        if (q1.size() != 0 || q0.size() != 6 || q0[5] !== 10'h300)
            $display("FAIL fs_damaged_out: got m1 %0d m0 %0d, want 0 6", q1.size(), q0.size());
        else pass_cnt++;
        total_cnt++;
        if (cnt_drop !== CW'(1) || cnt_ovr !== CW'(1) || cnt_fwd1 !== '0)
            $display("FAIL fs_damaged_cnt: got drop %0d ovr %0d fwd1 %0d, want 1 1 0",
                     cnt_drop, cnt_ovr, cnt_fwd1);
        else pass_cnt++;
        send_frame(MAC_ME, 16'h0800, 4, 0, 1'b1, 1'b0);
        repeat (3) cyc();
        total_cnt++;
        if (cnt_fwd0 !== CW'(1) || q0.size() != 10)
            $display("FAIL fs_after: got fwd0 %0d beats %0d, want 1 10", cnt_fwd0, q0.size());
        else pass_cnt++;
    endtask

    task automatic test_random();
        int m_f0, m_f1, m_dr, r, len;
        logic [47:0] dst;
        logic [15:0] et;
        bit acc;
        do_reset();
        m_f0 = 0;
        m_f1 = 0;
        m_dr = 0;
        cfg_mac = MAC_ME;
        for (int n = 0; n < 150; n++) begin
            cfg_promisc = ($urandom_range(3, 0) == 0);
            cfg_mcast_en = 1'($urandom);
            r = $urandom_range(4, 0);
            case (r)
                0: dst = cfg_mac;
                1: dst = BCAST;
                2: dst = {24'h01005E, 24'($urandom)};
                3: dst = {8'h02, 40'($urandom)};
                default: dst = {16'($urandom), $urandom};
            endcase
            r = $urandom_range(3, 0);
            et = (r == 0) ? 16'h0800 : (r == 1) ? 16'h0806 : (r == 2) ? 16'h86DD
                                                                  : 16'($urandom);
            len = $urandom_range(40, 1);
            acc = cfg_promisc || dst == cfg_mac || dst == BCAST || (cfg_mcast_en && dst[40]);
            if ($urandom_range(3, 0) == 0) begin
                s_tvalid = 1'b1;
                s_tdata = 8'($urandom);
                s_tlast = 1'($urandom);
                cyc();
                s_tvalid = 1'b0;
                s_tlast = 1'b0;
            end
            send_frame(dst, et, len, $urandom_range(2, 0), 1'b1, $urandom_range(2, 0) == 0);
            if (acc && et == 16'h0800) begin
                for (int i = 0; i < len; i++) eq0.push_back({1'b0, (i == len - 1), sent[i]});
                m_f0 = (m_f0 == int'(SAT)) ? m_f0 : m_f0 + 1;
            end else if (acc && et == 16'h0806) begin
                for (int i = 0; i < len; i++) eq1.push_back({1'b0, (i == len - 1), sent[i]});
                m_f1 = (m_f1 == int'(SAT)) ? m_f1 : m_f1 + 1;
            end else begin
                m_dr = (m_dr == int'(SAT)) ? m_dr : m_dr + 1;
            end
            repeat ($urandom_range(2, 1)) cyc();
        end
        repeat (4) cyc();
        total_cnt++;
        if (q0.size() != eq0.size() || q1.size() != eq1.size())
            $display("FAIL rand_sizes: got %0d/%0d, want %0d/%0d",
                     q0.size(), q1.size(), eq0.size(), eq1.size());
        else pass_cnt++;
        for (int i = 0; i < eq0.size() && i < q0.size(); i++) begin
            total_cnt++;
            if (q0[i] !== eq0[i]) $display("FAIL rand_m0[%0d]: got %h, want %h", i, q0[i], eq0[i]);
            else pass_cnt++;
        end
        for (int i = 0; i < eq1.size() && i < q1.size(); i++) begin
            total_cnt++;
            if (q1[i] !== eq1[i]) $display("FAIL rand_m1[%0d]: got %h, want %h", i, q1[i], eq1[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (int'(cnt_fwd0) != m_f0 || int'(cnt_fwd1) != m_f1 || int'(cnt_drop) != m_dr ||
            cnt_ovr !== '0)
            $display("FAIL rand_counters: got %0d %0d %0d %0d, want %0d %0d %0d 0",
                     cnt_fwd0, cnt_fwd1, cnt_drop, cnt_ovr, m_f0, m_f1, m_dr);
        else pass_cnt++;
        cfg_mac = MAC_ME;
        cfg_promisc = 1'b0;
        cfg_mcast_en = 1'b0;
    endtask

    task automatic test_saturation_and_reset();
        do_reset();
        cfg_mac = MAC_ME;
        cfg_promisc = 1'b0;
        for (int n = 0; n < int'(SAT); n++) begin
            send_frame(MAC_NO, 16'h0800, 1, 0, 1'b1, 1'b0);
        end
        cyc();
        total_cnt++;
        if (cnt_drop !== SAT)
            $display("FAIL sat_reach: got %0d, want %0d", cnt_drop, SAT);
        else pass_cnt++;
        send_frame(MAC_NO, 16'h0806, 3, 0, 1'b1, 1'b0);
        cyc();
        total_cnt++;
        if (cnt_drop !== SAT || cnt_fwd0 !== '0)
            $display("FAIL sat_hold: got drop %0d fwd0 %0d, want %0d 0", cnt_drop, cnt_fwd0, SAT);
        else pass_cnt++;

        m0_tready = 1'b0;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        s_tvalid = 1'b1;
        s_tdata = 8'hA5;
        dest_mac = MAC_ME;
        ethertype = 16'h0800;
        cyc();
        s_tvalid = 1'b0;
        total_cnt++;
        if (m0_tvalid !== 1'b1 || m0_tdata !== 8'hA5)
            $display("FAIL rst_pre: got v%b d%h, want v1 dA5", m0_tvalid, m0_tdata);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({m0_tvalid, m0_tdata, m0_tlast, m0_tuser, m1_tvalid, m1_tdata, m1_tlast, m1_tuser}
            !== 20'h0)
            $display("FAIL rst_mid_outputs: got m0 %b/%h, want 0/00", m0_tvalid, m0_tdata);
        else pass_cnt++;
        total_cnt++;
        if ({cnt_fwd0, cnt_fwd1, cnt_drop, cnt_ovr} !== '0)
            $display("FAIL rst_mid_counters: got drop %0d ovr %0d, want 0 0", cnt_drop, cnt_ovr);
        else pass_cnt++;
        cyc();
        rst = 1'b0;
        m0_tready = 1'b1;
        repeat (4) cyc();
        total_cnt++;
        if (q0.size() != 0 || m0_tvalid !== 1'b0)
            $display("FAIL rst_no_term: got %0d beats v%b, want 0 v0", q0.size(), m0_tvalid);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_ipv4_basic();
        test_arp_bcast_mcast();
        test_drop();
        test_overrun();
        test_midframe_start();
        test_random();
        test_saturation_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rx_ethertype_router.md
Name: rx_ethertype_router

Overview:
- Sits directly after the RX MAC (RGMII receiver + Ethernet parser) in the 125 MHz RX clock domain.
- Consumes the parser's payload stream, which has no backpressure, together with the parsed header fields.
- Applies a destination-MAC filter, then steers each accepted frame to one of two downstream AXI-Stream consumers by ethertype (port 0 IPv4, port 1 ARP). All other frames are discarded.
- Detects downstream overrun, terminates truncated frames with an error flag, and keeps per-outcome statistics.

Parameters:
- ETYPE0, 16'h0800, ethertype routed to port 0
- ETYPE1, 16'h0806, ethertype routed to port 1
- CNT_W, 16, width of the saturating statistics counters

Ports:
- clk125  in  1  RX-domain 125 MHz clock
- rst  in  1  asynchronous active-high reset
- cfg_mac  in  48  station MAC; bits [47:40] are the first byte on the wire
- cfg_promisc  in  1  accept any destination MAC
- cfg_mcast_en  in  1  accept multicast destinations (dest_mac[40]=1)
- frame_start  in  1  1-cycle pulse at the start of each frame, from the parser
- dest_mac  in  48  parsed destination MAC; valid from the first s_tvalid beat until s_tlast
- ethertype  in  16  parsed ethertype; valid over the same window as dest_mac
- s_tvalid  in  1  payload beat valid; no backpressure exists
- s_tdata  in  8  payload byte
- s_tlast  in  1  last payload beat of the frame
- m0_tvalid / m1_tvalid  out  1  output beat valid
- m0_tdata / m1_tdata  out  8  output byte
- m0_tlast / m1_tlast  out  1  last beat of the output frame
- m0_tuser / m1_tuser  out  1  frame error; qualified only together with tlast
- m0_tready / m1_tready  in  1  downstream ready
- cnt_fwd0 / cnt_fwd1  out  CNT_W  frames completed cleanly on port 0 / port 1
- cnt_drop  out  CNT_W  frames discarded by the filter or the ethertype match
- cnt_ovr  out  CNT_W  frames truncated by overrun

Behaviour:
- Single clock clk125. rst is asynchronous and active-high.
- Reset values: every m*_tvalid/tlast/tuser = 0, m*_tdata = 0, all counters = 0, state = IDLE.
- Each output port has one output register. A beat is transferred when tvalid && tready. tvalid, tdata, tlast and tuser hold stable until the beat is transferred.
- Latency: an input beat is presented on the selected port one clock after it arrives.
- Accept condition: cfg_promisc, OR dest_mac == cfg_mac, OR dest_mac == 48'hFFFF_FFFF_FFFF, OR (cfg_mcast_en && dest_mac[40]).
- Routing: sel = 0 if ethertype == ETYPE0; sel = 1 if ethertype == ETYPE1.
- State machine:
  - IDLE: frame_start → HDR. s_tvalid beats are ignored.
  - HDR: on the first s_tvalid beat, sample dest_mac and ethertype.
    - Accepted and routed → FWD(sel); the beat is loaded into port sel.
    - Otherwise → DISCARD and cnt_drop += 1.
    - If that first beat also has s_tlast, return to IDLE after the beat is loaded or discarded.
  - FWD(sel): each s_tvalid beat loads port sel.
    - If port sel's register still holds an untransferred beat when a new s_tvalid arrives, this is an overrun: the new beat is lost, cnt_ovr += 1, → ABORT.
    - On a clean s_tlast beat → IDLE. cnt_fwd(sel) += 1 when that tlast beat transfers.
  - DISCARD: s_tvalid beats are ignored. s_tlast → IDLE.
  - ABORT: once the held beat transfers, emit a terminator beat on port sel: tdata = 0, tlast = 1, tuser = 1. Then go to IDLE, or to HDR if a frame_start is pending.
    - Input beats arriving during ABORT are ignored.
- frame_start in FWD (previous frame truncated by the upstream MAC): treated as an overrun (cnt_ovr += 1, → ABORT) with frame_start latched as pending.
- frame_start in ABORT: latched as pending.
  - Any beats of the new frame that arrive before ABORT exits are discarded.
  - That new frame counts once toward cnt_drop; it does not enter HDR late.
- frame_start in HDR or DISCARD: restart in HDR.
- The non-selected port never asserts tvalid. At most one port is active per frame.
- Counters saturate at all-ones and never wrap. Multiple increments landing in the same cycle on different counters are independent.
- cfg_* inputs are sampled only at the HDR decision. Changing them mid-frame has no effect on the current frame.
- rst asserted mid-frame clears everything immediately. No terminator beat is emitted.

Test Plan:
- cfg_mac = 02:00:00:00:00:01, frame to that MAC, ethertype 0x0800, 46-byte payload, m0_tready = 1 → 46 beats on m0 one cycle after input, tlast on byte 46, tuser = 0, cnt_fwd0 = 1, m1 idle.
- Broadcast destination, ethertype 0x0806, 28 bytes → all 28 bytes on m1, cnt_fwd1 = 1. Repeat with dest 01:00:5E:00:00:01: dropped when cfg_mcast_en = 0, forwarded when cfg_mcast_en = 1.
- Frame to 02:00:00:00:00:99 with cfg_promisc = 0 → no output, cnt_drop = 1. Same frame with cfg_promisc = 1 but ethertype 0x86DD → no output, cnt_drop = 2.
- IPv4 frame with m0_tready forced low on beat 10 for 3 cycles → beats 1–9 plus the held beat 10 delivered, then terminator {tdata=0, tlast=1, tuser=1}; cnt_ovr = 1, cnt_fwd0 = 0; the next frame is forwarded normally.
- frame_start injected mid-IPv4 frame → terminator with tuser = 1 on m0, cnt_ovr = 1; the new frame is handled according to the pending-frame_start rules.
- Preload cnt_drop to 2^CNT_W − 1 via a long run of dropped frames, then send one more → counter holds at all-ones. Assert rst mid-frame → all outputs and counters return to 0 immediately.
